// File: rtl/queue_dispatcher.sv
// Routes a single word stream into per-class FIFOs through a one-word skid register,
// back-pressuring upstream while the target FIFO is full and flagging long blockages.
module queue_dispatcher #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8,
  parameter int STALL_LIMIT    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enb,
  input  logic [DATA_BITS-1:0]      data_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [QUEUE_QUANTITY-1:0] buf_full,
  output logic [QUEUE_QUANTITY-1:0] push,
  output logic [DATA_BITS-1:0]      data_out,
  output logic                      stalled,
  output logic [1:0]                stall_queue
);

  localparam logic ST_EMPTY  = 1'b0;
  localparam logic ST_LOADED = 1'b1;
  localparam logic [7:0] LIM = 8'(STALL_LIMIT);

  logic                 state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 stalled_q, stalled_d;
  logic [1:0]           sq_q, sq_d;

  logic [1:0] dest;
  logic       loaded, dest_full, push_any, accept, blocked;

  assign dest      = hold_q[DATA_BITS-1:DATA_BITS-2];
  assign loaded    = (state_q == ST_LOADED);
  // Only the selected full flag is ever looked at, so X on other queues is harmless.
  assign dest_full = buf_full[dest];
  assign push_any  = enb & loaded & ~dest_full;
  assign blocked   = enb & loaded & dest_full;
  assign in_ready  = enb & (~loaded | ~dest_full);
  assign accept    = in_valid & in_ready;

  always_comb begin
    push       = '0;
    push[dest] = push_any;
  end

  assign data_out    = hold_q;
  assign stalled     = stalled_q;
  assign stall_queue = sq_q;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    stalled_d = stalled_q;
    sq_d      = sq_q;
    if (enb) begin
      // Accept wins over drain so a push and a refill share one edge.
      if (accept) begin
        state_d = ST_LOADED;
        hold_d  = data_in;
      end else if (push_any) begin
        state_d = ST_EMPTY;
      end
      if (blocked) begin
        cnt_d = (cnt_q >= LIM) ? LIM : cnt_q + 8'd1;
        if (cnt_d == LIM) begin
          stalled_d = 1'b1;
          sq_d      = dest;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_EMPTY;
      hold_q    <= '0;
      cnt_q     <= '0;
      stalled_q <= 1'b0;
      sq_q      <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      stalled_q <= stalled_d;
      sq_q      <= sq_d;
    end
  end

endmodule

// File: doc/queue_dispatcher.md
Name: queue_dispatcher

Overview:
- Write-side counterpart of the round-robin read arbiter. Takes a single input word stream and pushes each word into one of QUEUE_QUANTITY class FIFOs.
- The destination queue is given by the class field in the upper bits of the word.
- Holds one word in a skid register and applies backpressure upstream while the target FIFO reports full.
- Flags prolonged blocking with a sticky stall indicator.

Parameters:
- QUEUE_QUANTITY, 4, number of destination FIFOs (fixed at 4 for this revision).
- DATA_BITS, 8, word width; class field is data_in[DATA_BITS-1:DATA_BITS-2].
- STALL_LIMIT, 8, consecutive blocked cycles before stalled asserts (2..255).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- enb  input  1  block enable; 0 freezes all state.
- data_in  input  DATA_BITS  incoming word; bits [DATA_BITS-1:DATA_BITS-2] select the queue.
- in_valid  input  1  upstream has a word on data_in.
- in_ready  output  1  block accepts data_in at this edge when in_valid=1.
- buf_full  input  QUEUE_QUANTITY  per-FIFO full flags.
- push  output  QUEUE_QUANTITY  one-hot FIFO write strobes.
- data_out  output  DATA_BITS  word presented to all FIFOs.
- stalled  output  1  sticky: held word blocked for STALL_LIMIT consecutive enabled cycles.
- stall_queue  output  2  index of the queue that caused the last stall assertion.

Behaviour:
- Reset (rst=0, asynchronous):
  - loaded=0; hold_reg=0; blocked counter=0.
  - stalled=0; stall_queue=0.
  - push=0; data_out=0.
  - A held word is discarded on reset mid-operation.
- State: two-state FSM, EMPTY (loaded=0) and LOADED (loaded=1). hold_reg holds the word; dest = hold_reg[DATA_BITS-1:DATA_BITS-2].
- Combinational outputs:
  - data_out = hold_reg (always, including when push=0).
  - push[i] = enb & loaded & (dest==i) & ~buf_full[i]. At most one bit is set.
  - in_ready = enb & (~loaded | ~buf_full[dest]), i.e. space or draining this cycle.
- Accept: at a clk edge with in_valid & in_ready, hold_reg <= data_in and loaded <= 1.
- Drain: at an edge with push nonzero and no accept, loaded <= 0.
- Simultaneous push and accept: the new word replaces the drained one and loaded stays 1, giving 1 word/cycle sustained throughput.
- Latency: a word accepted at edge N drives push during the cycle after edge N if its FIFO is not full.
- Blocked counter:
  - Increments at each edge where enb & loaded & buf_full[dest].
  - Clears on any push or when loaded=0.
  - Saturates at STALL_LIMIT.
  - When it reaches STALL_LIMIT: stalled <= 1 and stall_queue <= dest.
- stalled stays 1 until reset. If stalled is already 1, a later stall updates stall_queue.
- enb=0:
  - in_ready=0 and push=0.
  - hold_reg, loaded and counter are unchanged; in_valid is ignored.
- Ordering: words are pushed in acceptance order. A word for a full queue blocks words for all other queues (no reordering).
- buf_full changes take effect in the same cycle (combinational into push/in_ready). The FIFO must not write on push when it is full; the block guarantees push only when buf_full=0.
- Unknown/X on buf_full bits of non-selected queues has no effect on outputs.

Test Plan:
- Reset: rst=0 for 2 cycles with in_valid=1 -> push=0000, data_out=00, in_ready=0 during reset, stalled=0. After rst=1, enb=1 -> in_ready=1.
- Stream: enb=1, buf_full=0000, in_valid=1, words 0x05,0x47,0x8A,0xC3 on consecutive edges -> push=0001,0010,0100,1000 on consecutive cycles, each one cycle after acceptance; data_out matches; in_ready stays 1.
- Backpressure: buf_full=0001, send 0x11 then 0x52 -> 0x11 held, push=0000, in_ready=0, 0x52 waits. Release buf_full[0] -> push=0001 with data 0x11, then push=0010 with data 0x52; order preserved.
- Stall: buf_full=0100, send 0x9F, hold 8 cycles -> stalled=1 on the 8th blocked edge, stall_queue=2. Release -> push=0100; stalled stays 1.
- Enable freeze: word 0x33 loaded, enb=0 for 3 cycles with in_valid=1 and data 0x77 -> push=0000, in_ready=0, no accept. enb=1 -> push=0001 with 0x33, then 0x77 accepted and pushed on push=0010.
- Reset mid-operation: 0xE0 held with buf_full=1000, pulse rst=0 asynchronously mid-cycle -> loaded=0 immediately, push=0000, data_out=00. 0xE0 is never pushed after release.
